// File: rtl/arp_frame_responder.sv
// ARP frame responder: validates decoded ARP frames, issues cache writes and ARP replies.
// Optional statistics counters are enabled by defining ARP_RESP_STATS_EN.
module arp_frame_responder #(
    parameter bit          CACHE_ON_REQUEST = 1'b1,
    parameter int unsigned STAT_WIDTH       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_frame_valid,
    output logic        s_frame_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [15:0] s_arp_htype,
    input  logic [15:0] s_arp_ptype,
    input  logic [7:0]  s_arp_hlen,
    input  logic [7:0]  s_arp_plen,
    input  logic [15:0] s_arp_oper,
    input  logic [47:0] s_arp_sha,
    input  logic [31:0] s_arp_spa,
    input  logic [47:0] s_arp_tha,
    input  logic [31:0] s_arp_tpa,
    output logic        m_frame_valid,
    input  logic        m_frame_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [15:0] m_arp_htype,
    output logic [15:0] m_arp_ptype,
    output logic [7:0]  m_arp_hlen,
    output logic [7:0]  m_arp_plen,
    output logic [15:0] m_arp_oper,
    output logic [47:0] m_arp_sha,
    output logic [31:0] m_arp_spa,
    output logic [47:0] m_arp_tha,
    output logic [31:0] m_arp_tpa,
    output logic        m_cache_wr_valid,
    input  logic        m_cache_wr_ready,
    output logic [31:0] m_cache_wr_ip,
    output logic [47:0] m_cache_wr_mac,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    output logic        busy,
    output logic        drop
`ifdef ARP_RESP_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_req_rx,
    output logic [STAT_WIDTH-1:0] stat_reply_tx,
    output logic [STAT_WIDTH-1:0] stat_drop
`endif
);

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state;

    logic accept, hdr_ok, tpa_local, want_reply, want_cache;
    logic reply_pending, cache_pending;
    logic unused_fields;

    assign unused_fields = ^{s_eth_dest_mac, s_eth_src_mac, s_eth_type, s_arp_tha};

    assign s_frame_ready = (state == IDLE) && !rst;
    assign busy          = (state != IDLE);
    assign accept        = s_frame_valid && s_frame_ready;

    // A zero sender IP is a probe and is never learned, whatever else matched.
    always_comb begin
        hdr_ok     = (s_arp_htype == 16'd1) && (s_arp_ptype == 16'h0800) &&
                     (s_arp_hlen == 8'd6) && (s_arp_plen == 8'd4) &&
                     ((s_arp_oper == 16'd1) || (s_arp_oper == 16'd2));
        tpa_local  = (s_arp_tpa == local_ip);
        want_reply = hdr_ok && (s_arp_oper == 16'd1) && tpa_local && (local_ip != '0);
        want_cache = hdr_ok && (s_arp_spa != '0) &&
                     ((want_reply && CACHE_ON_REQUEST) ||
                      ((s_arp_oper == 16'd2) && tpa_local) ||
                      (s_arp_spa == s_arp_tpa));
    end

    assign reply_pending = m_frame_valid && !m_frame_ready;
    assign cache_pending = m_cache_wr_valid && !m_cache_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            drop             <= 1'b0;
            m_frame_valid    <= 1'b0;
            m_cache_wr_valid <= 1'b0;
            m_eth_dest_mac   <= '0;
            m_eth_src_mac    <= '0;
            m_eth_type       <= '0;
            m_arp_htype      <= '0;
            m_arp_ptype      <= '0;
            m_arp_hlen       <= '0;
            m_arp_plen       <= '0;
            m_arp_oper       <= '0;
            m_arp_sha        <= '0;
            m_arp_spa        <= '0;
            m_arp_tha        <= '0;
            m_arp_tpa        <= '0;
            m_cache_wr_ip    <= '0;
            m_cache_wr_mac   <= '0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (want_reply || want_cache) begin
                            state            <= ISSUE;
                            m_frame_valid    <= want_reply;
                            m_cache_wr_valid <= want_cache;
                            m_eth_dest_mac   <= s_arp_sha;
                            m_eth_src_mac    <= local_mac;
                            m_eth_type       <= 16'h0806;
                            m_arp_htype      <= 16'd1;
                            m_arp_ptype      <= 16'h0800;
                            m_arp_hlen       <= 8'd6;
                            m_arp_plen       <= 8'd4;
                            m_arp_oper       <= 16'd2;
                            m_arp_sha        <= local_mac;
                            m_arp_spa        <= local_ip;
                            m_arp_tha        <= s_arp_sha;
                            m_arp_tpa        <= s_arp_spa;
                            m_cache_wr_ip    <= s_arp_spa;
                            m_cache_wr_mac   <= s_arp_sha;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (m_frame_valid && m_frame_ready)
                        m_frame_valid <= 1'b0;
                    if (m_cache_wr_valid && m_cache_wr_ready)
                        m_cache_wr_valid <= 1'b0;
                    if (!reply_pending && !cache_pending)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARP_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_rx   <= '0;
            stat_reply_tx <= '0;
            stat_drop     <= '0;
        end else begin
            if (accept && (s_arp_oper == 16'd1))
                stat_req_rx <= stat_req_rx + 1'b1;
            if (m_frame_valid && m_frame_ready)
                stat_reply_tx <= stat_reply_tx + 1'b1;
            if (drop)
                stat_drop <= stat_drop + 1'b1;
        end
    end
`endif

endmodule
